// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64 KiB byte-addressed memory between instruction fetch and
// the load/store unit, with store byte-enables, load extension and DM error flagging.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_funct3,
  input  logic [15:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic [3:0]  mem_w_en,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  starve_cnt_reg;
  logic        sel_dm_reg, we_reg, err_reg;
  logic [2:0]  f3_reg;
  logic [15:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        if_valid_reg, dm_valid_reg, dm_err_reg;
  logic [31:0] if_rdata_reg, dm_rdata_reg;

  logic        dm_grant, accept, dm_bad;
  logic [31:0] load_ext;

  // DM wins a tie unless fetch has already lost LIMIT times in a row.
  assign dm_grant = dm_req && !(if_req && (starve_cnt_reg == LIMIT));
  assign accept   = if_ready || dm_ready;

  always_comb begin
    dm_bad = 1'b0;
    case (dm_funct3[1:0])
      2'b01:   dm_bad = dm_addr[0];
      2'b10:   dm_bad = (dm_addr[1:0] != 2'b00);
      2'b11:   dm_bad = 1'b1;
      default: dm_bad = 1'b0;
    endcase
    if (dm_funct3[2] && (dm_we || dm_funct3[1]))
      dm_bad = 1'b1;
  end

  always_comb begin
    case (f3_reg)
      3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_ext = {24'd0, mem_rdata[7:0]};
      3'b101:  load_ext = {16'd0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    mem_w_en  = 4'b0000;
    mem_addr  = addr_reg;
    mem_wdata = wdata_reg;
    if (state_reg == IDLE) begin
      dm_ready = dm_grant;
      if_ready = if_req && !dm_grant;
    end else if (sel_dm_reg && we_reg && !err_reg) begin
      case (f3_reg)
        3'b000:  mem_w_en = 4'b0001;
        3'b001:  mem_w_en = 4'b0011;
        default: mem_w_en = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= 4'd0;
      sel_dm_reg     <= 1'b0;
      we_reg         <= 1'b0;
      err_reg        <= 1'b0;
      f3_reg         <= 3'd0;
      addr_reg       <= 16'd0;
      wdata_reg      <= 32'd0;
    end else if (dm_ready) begin
      sel_dm_reg <= 1'b1;
      we_reg     <= dm_we;
      err_reg    <= dm_bad;
      f3_reg     <= dm_funct3;
      addr_reg   <= dm_addr;
      wdata_reg  <= dm_wdata;
      if (if_req && (starve_cnt_reg < LIMIT))
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end else if (if_ready) begin
      sel_dm_reg     <= 1'b0;
      we_reg         <= 1'b0;
      err_reg        <= 1'b0;
      f3_reg         <= 3'b010;
      addr_reg       <= if_addr;
      starve_cnt_reg <= 4'd0;
    end
  end

  // Responses are registered at the closing edge of ACCESS; rdata holds until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
      dm_err_reg   <= 1'b0;
      if_rdata_reg <= 32'd0;
      dm_rdata_reg <= 32'd0;
    end else begin
      if_valid_reg <= (state_reg == ACCESS) && !sel_dm_reg;
      dm_valid_reg <= (state_reg == ACCESS) && sel_dm_reg;
      dm_err_reg   <= 1'b0;
      if (state_reg == ACCESS) begin
        if (!sel_dm_reg) begin
          if_rdata_reg <= mem_rdata;
        end else begin
          dm_err_reg   <= err_reg;
          dm_rdata_reg <= (we_reg || err_reg) ? 32'd0 : load_ext;
        end
      end
    end
  end

  assign if_valid = if_valid_reg;
  assign if_rdata = if_rdata_reg;
  assign dm_valid = dm_valid_reg;
  assign dm_err   = dm_err_reg;
  assign dm_rdata = dm_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a little-endian byte memory model attached.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'd0;
  logic        if_ready, if_valid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [2:0]  dm_funct3 = 3'd0;
  logic [15:0] dm_addr = 16'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic        dm_ready, dm_valid, dm_err;
  logic [31:0] dm_rdata;
  logic [3:0]  mem_w_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0] mem [0:65535];
  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_valid(dm_valid),
    .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {mem[mem_addr + 16'd3], mem[mem_addr + 16'd2],
                      mem[mem_addr + 16'd1], mem[mem_addr]};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_w_en[k]) mem[mem_addr + 16'(k)] <= mem_wdata[8*k +: 8];
  end

  // One DM transaction: present at a negedge, accept, ACCESS, response cycle.
  task automatic dm_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] exp_wen, input logic exp_err,
                       input logic [31:0] exp_rdata);
    @(negedge clk);
    dm_req = 1'b1; dm_we = we; dm_funct3 = f3; dm_addr = addr; dm_wdata = wdata;
    #1;
    checks++;
    if (dm_ready !== 1'b1) begin
      errors++; $display("FAIL %s dm_ready: got %b want 1", name, dm_ready);
    end
    @(posedge clk); #1;
    dm_req = 1'b0;
    checks++;
    if (mem_w_en !== exp_wen || mem_addr !== addr) begin
      errors++;
      $display("FAIL %s access: w_en=%b addr=%h want w_en=%b addr=%h",
               name, mem_w_en, mem_addr, exp_wen, addr);
    end
    @(posedge clk); #1;
    checks++;
    if (dm_valid !== 1'b1 || dm_err !== exp_err || dm_rdata !== exp_rdata || mem_w_en !== 4'b0000) begin
      errors++;
      $display("FAIL %s response: valid=%b err=%b rdata=%h w_en=%b want 1 %b %h 0000",
               name, dm_valid, dm_err, dm_rdata, mem_w_en, exp_err, exp_rdata);
    end
    $display("dm %s addr=%h rdata=%h err=%b", name, addr, dm_rdata, dm_err);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (if_ready !== 0 || dm_ready !== 0 || if_valid !== 0 || dm_valid !== 0 || dm_err !== 0 ||
        if_rdata !== 0 || dm_rdata !== 0 || mem_w_en !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (w_en=%b addr=%h rdata=%h/%h)",
               mem_w_en, mem_addr, if_rdata, dm_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0000;
    #1;
    checks++;
    if (if_ready !== 1'b1 || dm_ready !== 1'b0) begin
      errors++; $display("FAIL fetch_ready: if=%b dm=%b want 1 0", if_ready, dm_ready);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    checks++;
    if (mem_w_en !== 4'b0000 || mem_addr !== 16'h0000 || if_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_access: w_en=%b addr=%h valid=%b want 0000 0000 0", mem_w_en, mem_addr, if_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00000013 || mem_w_en !== 4'b0000) begin
      errors++; $display("FAIL fetch_resp: valid=%b rdata=%h want 1 00000013", if_valid, if_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h00000013) begin
      errors++; $display("FAIL fetch_pulse: valid=%b rdata=%h want 0 00000013", if_valid, if_rdata);
    end
    $display("fetch addr=0000 rdata=%h", if_rdata);
  endtask

  task automatic test_store_load();
    dm_op("sw",  1'b1, 3'b010, 16'h0100, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h00000000);
    dm_op("lb",  1'b0, 3'b000, 16'h0100, 32'h0, 4'b0000, 1'b0, 32'hFFFFFFEF);
    dm_op("lbu", 1'b0, 3'b100, 16'h0100, 32'h0, 4'b0000, 1'b0, 32'h000000EF);
    dm_op("lh",  1'b0, 3'b001, 16'h0100, 32'h0, 4'b0000, 1'b0, 32'hFFFFBEEF);
    dm_op("lhu", 1'b0, 3'b101, 16'h0100, 32'h0, 4'b0000, 1'b0, 32'h0000BEEF);
    dm_op("lw",  1'b0, 3'b010, 16'h0100, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF);
    dm_op("lb2", 1'b0, 3'b000, 16'h0101, 32'h0, 4'b0000, 1'b0, 32'hFFFFFFBE);
  endtask

  task automatic test_byte_store();
    dm_op("sb",    1'b1, 3'b000, 16'h0103, 32'h000000AA, 4'b0001, 1'b0, 32'h00000000);
    dm_op("lw_sb", 1'b0, 3'b010, 16'h0100, 32'h0, 4'b0000, 1'b0, 32'hAAADBEEF);
  endtask

  task automatic test_errors();
    dm_op("lw_mis",  1'b0, 3'b010, 16'h0102, 32'h0, 4'b0000, 1'b1, 32'h0);
    dm_op("sh_mis",  1'b1, 3'b001, 16'h0101, 32'h11223344, 4'b0000, 1'b1, 32'h0);
    dm_op("st_f011", 1'b1, 3'b011, 16'h0100, 32'h55667788, 4'b0000, 1'b1, 32'h0);
    dm_op("ld_f110", 1'b0, 3'b110, 16'h0100, 32'h0, 4'b0000, 1'b1, 32'h0);
    dm_op("lw_keep", 1'b0, 3'b010, 16'h0100, 32'h0, 4'b0000, 1'b0, 32'hAAADBEEF);
  endtask

  task automatic test_starve();
    int cnt = 0;
    logic exp_dm;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0000;
    dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 16'h0100;
    for (int g = 0; g < 10; g++) begin
      #1;
      exp_dm = (cnt != 4);
      checks++;
      if (dm_ready !== exp_dm || if_ready !== !exp_dm) begin
        errors++;
        $display("FAIL starve_grant%0d: dm_ready=%b if_ready=%b want %b %b",
                 g, dm_ready, if_ready, exp_dm, !exp_dm);
      end
      $display("grant %0d: %s", g, dm_ready ? "DM" : (if_ready ? "IF" : "none"));
      cnt = exp_dm ? cnt + 1 : 0;
      @(negedge clk);
      checks++;
      if (dm_ready !== 1'b0 || if_ready !== 1'b0) begin
        errors++; $display("FAIL starve_access%0d: dm_ready=%b if_ready=%b want 0 0", g, dm_ready, if_ready);
      end
      @(negedge clk);
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 16'h0200; dm_wdata = 32'h12345678;
    @(posedge clk); #1;
    dm_req = 1'b0;
    checks++;
    if (mem_w_en !== 4'b1111) begin
      errors++; $display("FAIL rst_access_wen: got %b want 1111", mem_w_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_w_en !== 4'b0000 || mem_addr !== 16'h0000) begin
      errors++; $display("FAIL rst_drop: w_en=%b addr=%h want 0000 0000", mem_w_en, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (dm_valid !== 1'b0) begin
      errors++; $display("FAIL rst_no_valid: dm_valid=%b want 0", dm_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    $display("reset mid-access released");
    dm_op("lw_after_rst", 1'b0, 3'b010, 16'h0200, 32'h0, 4'b0000, 1'b0, 32'hCAFEF00D);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h13;
    {mem[16'h0203], mem[16'h0202], mem[16'h0201], mem[16'h0200]} = 32'hCAFEF00D;
    test_reset();
    test_fetch();
    test_store_load();
    test_byte_store();
    test_errors();
    test_starve();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported, byte-addressed 64 KiB memory between the instruction-fetch stage (IF) and the load/store unit (DM) of the pipeline.
- Sequences each access as IDLE -> ACCESS.
- Generates store byte-enables from RISC-V funct3 and sign/zero-extends load data.
- Flags misaligned or illegal DM accesses.
- Sits between the pipeline stages and the memory's w_en/address/write_data/read_data pins.

Parameters:
STARVE_LIMIT, 4, consecutive IF losses before IF is forced to win (1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until accepted
if_addr  in  16  fetch byte address
if_ready  out  1  fetch accepted this cycle (combinational)
if_valid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  32  fetched word
dm_req  in  1  data request, held until accepted
dm_we  in  1  1 = store, 0 = load
dm_funct3  in  3  RISC-V load/store funct3
dm_addr  in  16  data byte address
dm_wdata  in  32  store data, right-aligned
dm_ready  out  1  data request accepted this cycle (combinational)
dm_valid  out  1  one-cycle pulse, load data or store completion
dm_rdata  out  32  extended load data, 0 for stores and errors
dm_err  out  1  qualifies dm_valid: misaligned or illegal funct3
mem_w_en  out  4  memory byte write enables
mem_addr  out  16  memory byte address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE; starve_cnt=0; all out valids/readies/err=0; if_rdata=dm_rdata=0; mem_w_en=0 and mem_addr/mem_wdata=0 immediately.
- Arbitration:
  - Only in IDLE.
  - If both requests are present, DM wins unless starve_cnt==STARVE_LIMIT.
  - The winner's ready=1 and the other's ready=0. Only one ready is ever high.
  - A req high with its ready high is an accept; command fields are registered at that edge.
  - Accepting DM while if_req=1 increments starve_cnt (saturating). Accepting IF clears it.
- ACCESS (one cycle after accept):
  - Both readies=0.
  - mem_addr = registered address.
  - Fetch/load: mem_w_en=0; mem_rdata is captured at the closing edge.
  - Store: mem_w_en = 0001 (sb, f3=000), 0011 (sh, 001), 1111 (sw, 010); mem_wdata = dm_wdata unshifted. The memory writes byte k at address+k.
  - Next state is always IDLE.
- Response: the valid pulse is high for the cycle after ACCESS (coincident with IDLE, which may accept a new request).
  - Latency accept->valid = 2 cycles.
  - Throughput = 1 access per 2 cycles.
  - rdata holds until the next response.
- Load extension from the captured word w:
  - lb (000) = sext(w[7:0])
  - lh (001) = sext(w[15:0])
  - lw (010) = w
  - lbu (100) = zext(w[7:0])
  - lhu (101) = zext(w[15:0])
- Errors: dm_err=1 with dm_valid, dm_rdata=0, and mem_w_en stays 0000 in ACCESS (no write). Latency is unchanged. Error cases:
  - halfword access with addr[0]=1
  - word access with addr[1:0]!=0
  - load funct3 in {011,110,111}
  - store funct3 >= 011
- Fetch addresses are not alignment-checked. Address arithmetic wraps mod 2^16 (memory behaviour).
- Outside ACCESS, mem_w_en=0000 always, so memory reads are never blocked.
- Dropping req before accept cancels the request cleanly.
- Reset mid-ACCESS: the write is suppressed, the pending response is discarded, and the block returns to IDLE.

Test Plan:
- Reset release, then if_req with if_addr=0x0000 and mem word 0x00000013 -> if_ready high at the accept cycle; if_valid pulses 2 cycles later with if_rdata=0x00000013; mem_w_en=0 throughout.
- sw dm_addr=0x0100, dm_wdata=0xDEADBEEF, then lb/lbu/lh/lhu/lw at 0x0100 -> mem_w_en=1111 for exactly one cycle. Loads return, in order: 0xFFFFFFEF, 0x000000EF, 0xFFFFBEEF, 0x0000BEEF, 0xDEADBEEF.
- sb 0x0103 with wdata 0x000000AA, then lw 0x0100 -> 0xAAADBEEF; store mem_w_en=0001 with mem_addr=0x0103.
- Misaligned cases: lw 0x0102, sh 0x0101, funct3=011 store -> dm_valid with dm_err=1 and dm_rdata=0; memory unchanged (a later lw 0x0100 still returns 0xAAADBEEF).
- if_req and dm_req held high continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF repeating; starve_cnt never exceeds 4; never both readies high.
- rst_n low during the ACCESS cycle of sw 0x0200 with wdata=0x12345678 -> mem_w_en drops to 0 at once; no dm_valid; after release, lw 0x0200 returns the prior contents.
